// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF batch controller and its response serializer.
package puf_ctrl_pkg;

  localparam int CHAL_W     = 128;
  localparam int RESP_WORDS = 16;
  localparam int WORD_W     = 32;
  localparam int BUF_W      = RESP_WORDS * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Word idx of the captured response buffer, word 0 in the least significant bits.
  function automatic logic [WORD_W-1:0] buf_word(input logic [BUF_W-1:0] buffer,
                                                 input logic [3:0]       idx);
    return buffer[{idx, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// Holds the captured 512-bit response and streams it out as 16 words over a valid/ready link.
module resp_serializer
  import puf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BUF_W-1:0]  resp_in,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_valid,
  output logic              last_accept
);

  localparam logic [3:0] LAST_IDX = 4'(RESP_WORDS - 1);

  logic [BUF_W-1:0] resp_buf_r;
  logic [3:0]       word_idx_r;
  logic             accept_s;

  assign accept_s    = resp_valid && resp_ready;
  assign last_accept = accept_s && (word_idx_r == LAST_IDX);

  // Buffer capture and word advance; the next word is loaded only once the current one is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_buf_r <= '0;
      word_idx_r <= 4'd0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
    end else if (load) begin
      resp_buf_r <= resp_in;
      word_idx_r <= 4'd0;
      resp_data  <= resp_in[WORD_W-1:0];
      resp_valid <= 1'b1;
    end else if (accept_s) begin
      if (word_idx_r == LAST_IDX) begin
        resp_valid <= 1'b0;
      end else begin
        word_idx_r <= word_idx_r + 4'd1;
        resp_data  <= buf_word(resp_buf_r, word_idx_r + 4'd1);
      end
    end
  end

endmodule

// File: rtl/puf_batch_controller.sv
// Batch sequencer for a serial PUF driver stage: fetches challenges, runs the driver with a
// timeout, and drains each 512-bit response as 16 stream words.
module puf_batch_controller
  import puf_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int MIN_START_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                runStart,
  input  logic [15:0]         numChal,
  input  logic                chalValid,
  output logic                chalReady,
  input  logic [2*CHAL_W-1:0] chalData,
  output logic [CHAL_W-1:0]   challengeA,
  output logic [CHAL_W-1:0]   challengeB,
  output logic                exStart,
  input  logic                exDone,
  input  logic [CHAL_W-1:0]   respUp,
  input  logic [CHAL_W-1:0]   respUpNot,
  input  logic [CHAL_W-1:0]   respDown,
  input  logic [CHAL_W-1:0]   respDownNot,
  output logic [WORD_W-1:0]   respData,
  output logic                respValid,
  input  logic                respReady,
  output logic                runDone,
  output logic                errTimeout,
  output logic [15:0]         chalCount
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(MIN_START_CYCLES - 1);

  state_t        state_r;
  state_t        state_s;
  logic [15:0]   num_chal_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [15:0]   count_next_s;
  logic          start_accept_s;
  logic          fetch_accept_s;
  logic          capture_s;
  logic          timeout_s;
  logic          last_accept_s;

  resp_serializer u_resp_serializer (
    .clk         (clk),
    .rst         (rst),
    .load        (capture_s),
    .resp_in     ({respDownNot, respDown, respUpNot, respUp}),
    .resp_ready  (respReady),
    .resp_data   (respData),
    .resp_valid  (respValid),
    .last_accept (last_accept_s)
  );

  // Next-state and strobe decode.
  always_comb begin
    state_s        = state_r;
    start_accept_s = 1'b0;
    fetch_accept_s = 1'b0;
    capture_s      = 1'b0;
    timeout_s      = 1'b0;
    count_next_s   = chalCount + 16'd1;
    case (state_r)
      ST_IDLE: begin
        if (runStart) begin
          start_accept_s = 1'b1;
          state_s        = (numChal == 16'd0) ? ST_DONE : ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (chalValid && chalReady) begin
          fetch_accept_s = 1'b1;
          state_s        = ST_ISSUE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      // A level left high by the previous execution must fall before we wait for completion.
      ST_ISSUE: begin
        if (tmo_cnt_r == TMO_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_DONE;
        end else if ((tmo_cnt_r >= START_LAST) && !exDone) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (exDone) begin
          capture_s = 1'b1;
          state_s   = ST_DRAIN;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (last_accept_s) begin
          state_s = (count_next_s == num_chal_r) ? ST_DONE : ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, registered handshake outputs, batch bookkeeping and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      num_chal_r <= 16'd0;
      tmo_cnt_r  <= '0;
      chalReady  <= 1'b0;
      exStart    <= 1'b0;
      runDone    <= 1'b0;
      errTimeout <= 1'b0;
      chalCount  <= 16'd0;
      challengeA <= '0;
      challengeB <= '0;
    end else begin
      state_r   <= state_s;
      chalReady <= (state_s == ST_FETCH);
      exStart   <= (state_s == ST_ISSUE);
      runDone   <= (state_r == ST_DONE);
      if (start_accept_s) begin
        num_chal_r <= numChal;
        chalCount  <= 16'd0;
        errTimeout <= 1'b0;
      end else begin
        if (timeout_s) begin
          errTimeout <= 1'b1;
        end
        if (last_accept_s) begin
          chalCount <= count_next_s;
        end
      end
      if (fetch_accept_s) begin
        challengeA <= chalData[CHAL_W-1:0];
        challengeB <= chalData[2*CHAL_W-1:CHAL_W];
        tmo_cnt_r  <= '0;
      end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_puf_batch_controller.sv
// Randomized bench for puf_batch_controller: a behavioural driver-stage model and a word
// scoreboard built from the challenge/response traffic the bench itself generates.
`timescale 1ns/1ps
module tb_puf_batch_controller;

  localparam int           TMO   = 1200;
  localparam int           MIN   = 8;
  localparam logic [127:0] FIX_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] FIX_B = 128'hFEDCBA9876543210FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst;
  logic         runStart;
  logic [15:0]  numChal;
  logic         chalValid;
  logic         chalReady;
  logic [255:0] chalData;
  logic [127:0] challengeA;
  logic [127:0] challengeB;
  logic         exStart;
  logic         exDone;
  logic [127:0] respUp;
  logic [127:0] respUpNot;
  logic [127:0] respDown;
  logic [127:0] respDownNot;
  logic [31:0]  respData;
  logic         respValid;
  logic         respReady;
  logic         runDone;
  logic         errTimeout;
  logic [15:0]  chalCount;

  always #5 clk = ~clk;

  puf_batch_controller #(
    .TIMEOUT_CYCLES  (TMO),
    .MIN_START_CYCLES(MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .runStart   (runStart),
    .numChal    (numChal),
    .chalValid  (chalValid),
    .chalReady  (chalReady),
    .chalData   (chalData),
    .challengeA (challengeA),
    .challengeB (challengeB),
    .exStart    (exStart),
    .exDone     (exDone),
    .respUp     (respUp),
    .respUpNot  (respUpNot),
    .respDown   (respDown),
    .respDownNot(respDownNot),
    .respData   (respData),
    .respValid  (respValid),
    .respReady  (respReady),
    .runDone    (runDone),
    .errTimeout (errTimeout),
    .chalCount  (chalCount)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int drv_rise   = 20;
  int drv_fall   = 0;
  bit drv_never  = 1'b0;
  int rdy_mode   = 0;
  bit chal_fixed = 1'b0;

  logic [31:0]  exp_q[$];
  logic [255:0] chal_q[$];
  int words_seen = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int ready_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand128(output logic [127:0] v);
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
  endtask

  // Challenge source
  initial begin : chal_source
    chalValid = 1'b0;
    chalData  = '0;
    forever begin
      @(posedge clk); #1;
      if (chal_fixed) begin
        chalValid = 1'b1;
        chalData  = {FIX_B, FIX_A};
      end else begin
        chalValid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) chalData[i*32 +: 32] = $urandom;
      end
    end
  end

  // Response sink backpressure: 0 always ready, 1 toggling, 2 random
  initial begin : resp_sink
    respReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       respReady = 1'b1;
        1:       respReady = ~respReady;
        default: respReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Driver-stage model: exDone falls drv_fall cycles and rises drv_rise cycles after exStart rises
  initial begin : driver_stage
    int           st_cyc;
    int           exp_len;
    bit           pending;
    bit           prev_start;
    bit           prev_err;
    bit           high_at_start;
    logic [255:0] c;
    logic [127:0] vec[4];
    st_cyc = 0; pending = 1'b0; prev_start = 1'b0; prev_err = 1'b0; high_at_start = 1'b0;
    exDone = 1'b0;
    rand128(respUp); rand128(respUpNot); rand128(respDown); rand128(respDownNot);
    forever begin
      @(posedge clk); #1;
      if (exStart && !prev_start) begin
        st_cyc        = cyc;
        pending       = 1'b1;
        high_at_start = exDone;
        check_eq("chal_handshakes", chal_q.size(), 1);
        if (chal_q.size() > 0) begin
          c = chal_q.pop_front();
          check_eq("challengeA", challengeA, c[127:0]);
          check_eq("challengeB", challengeB, c[255:128]);
        end
      end
      if (!exStart && prev_start) begin
        exp_len = MIN;
        if (high_at_start && (drv_fall + 1 > exp_len)) exp_len = drv_fall + 1;
        if (exp_len > TMO) exp_len = TMO;
        check_eq("exstart_len", cyc - st_cyc, exp_len);
      end
      if (errTimeout && !prev_err) begin
        check_eq("timeout_cycle", cyc - st_cyc, TMO);
        check_eq("timeout_exstart", exStart, 1'b0);
      end
      prev_start = exStart;
      prev_err   = errTimeout;
      if (pending && (cyc - st_cyc == drv_fall)) begin
        exDone = 1'b0;
        rand128(respUp); rand128(respUpNot); rand128(respDown); rand128(respDownNot);
      end
      if (pending && !drv_never && (cyc - st_cyc == drv_rise)) begin
        rand128(respUp); rand128(respUpNot); rand128(respDown); rand128(respDownNot);
        exDone  = 1'b1;
        pending = 1'b0;
        vec = '{respUp, respUpNot, respDown, respDownNot};
        for (int v = 0; v < 4; v++)
          for (int i = 0; i < 4; i++) exp_q.push_back(vec[v][i*32 +: 32]);
      end
    end
  end

  // Observation on the falling edge: handshakes, run completion, word scoreboard
  initial begin : monitor
    bit          held;
    logic [31:0] held_data;
    logic [31:0] w;
    held = 1'b0; held_data = '0;
    forever begin
      @(negedge clk);
      if (chalValid && chalReady) chal_q.push_back(chalData);
      if (chalReady) ready_cnt++;
      if (runDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (respValid) begin
        if (held) check_eq("resp_stable", respData, held_data);
        if (respReady) begin
          check_eq("resp_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_eq("resp_word", respData, w);
          end
          words_seen++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = respData;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic run_batch(input int n, input int mode, input int rise, input int fall, input bit never);
    int d0, w0, r0, s0, exp_cnt, budget, k;
    drv_rise = rise; drv_fall = fall; drv_never = never; rdy_mode = mode;
    d0 = done_cnt; w0 = words_seen; r0 = ready_cnt;
    exp_cnt = never ? 0 : n;
    budget  = (n + 1) * (TMO + 200);
    @(posedge clk); #1;
    numChal  = 16'(n);
    runStart = 1'b1;
    s0       = cyc;
    @(posedge clk); #1;
    runStart = 1'b0;
    numChal  = 16'($urandom);
    check_eq("err_cleared", errTimeout, 1'b0);
    check_eq("count_cleared", chalCount, 16'd0);
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      runStart = (k == 20);
      numChal  = 16'($urandom);
    end
    runStart = 1'b0;
    check_eq("run_done", done_cnt - d0, 1);
    check_eq("chal_count", chalCount, 16'(exp_cnt));
    check_eq("err_timeout", errTimeout, never);
    check_eq("word_total", words_seen - w0, 16 * exp_cnt);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    if (n == 0) begin
      check_eq("zero_done_latency", done_cyc - s0, 2);
      check_eq("zero_no_chal_ready", ready_cnt - r0, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("single_done_pulse", done_cnt - d0, 1);
  endtask

  initial begin : main
    int w0, k;
    rst = 1'b1; runStart = 1'b0; numChal = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_exstart", exStart, 1'b0);
    check_eq("rst_chalready", chalReady, 1'b0);
    check_eq("rst_respvalid", respValid, 1'b0);
    check_eq("rst_rundone", runDone, 1'b0);
    check_eq("rst_errtimeout", errTimeout, 1'b0);
    check_eq("rst_chalcount", chalCount, 16'd0);
    check_eq("rst_challengeA", challengeA, 128'd0);
    check_eq("rst_challengeB", challengeB, 128'd0);
    check_eq("rst_respdata", respData, 32'd0);
    rst = 1'b0;

    chal_fixed = 1'b1;
    run_batch(1, 0, 1100, 0, 1'b0);
    check_eq("fixed_challengeA", challengeA, FIX_A);
    chal_fixed = 1'b0;
    run_batch(3, 1, 40, 0, 1'b0);
    run_batch(2, 2, 60, 30, 1'b0);
    run_batch(0, 0, 20, 0, 1'b0);
    run_batch(2, 0, 0, 100000, 1'b1);
    run_batch(1, 2, 0, 5, 1'b1);
    for (int r = 0; r < 4; r++) begin
      int fd, rd;
      fd = int'($urandom_range(0, 12));
      rd = fd + MIN + int'($urandom_range(3, 40));
      run_batch(int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), rd, fd, 1'b0);
    end

    rdy_mode = 0; drv_rise = 25; drv_fall = 0; drv_never = 1'b0;
    w0 = words_seen;
    @(posedge clk); #1;
    numChal = 16'd2; runStart = 1'b1;
    @(posedge clk); #1;
    runStart = 1'b0;
    k = 0;
    while ((words_seen - w0 < 7) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain_word7_reached", words_seen - w0, 7);
    check_eq("drain_word7_valid", respValid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_respvalid", respValid, 1'b0);
    check_eq("mid_rst_exstart", exStart, 1'b0);
    check_eq("mid_rst_chalready", chalReady, 1'b0);
    check_eq("mid_rst_chalcount", chalCount, 16'd0);
    check_eq("mid_rst_respdata", respData, 32'd0);
    exp_q.delete();
    chal_q.delete();
    run_batch(2, 2, 30, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/puf_batch_controller.md
PUF_BATCH_CONTROLLER -- requirements
Module: puf_batch_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles allowed in ISSUE plus WAIT per challenge.
REQ-002 Parameter MIN_START_CYCLES, default 8: minimum clk cycles exStart is held high (at least two PH1 periods).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; also drives the serial-PUF driver stage.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 runStart  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE.
REQ-007 numChal  in  16  number of challenge pairs in the batch, sampled on runStart; 0 is legal.
REQ-008 chalValid / chalReady  in / out  1 / 1  challenge-stream handshake.
REQ-009 chalData  in  256  {challengeB[127:0], challengeA[127:0]}.
REQ-010 challengeA, challengeB  out  128 each  registered challenges to the driver stage, held stable from FETCH until the next FETCH.
REQ-011 exStart  out  1  execution request to the driver stage.
REQ-012 exDone  in  1  driver-stage completion level; remains high after completion until the next execution starts.
REQ-013 respUp, respUpNot, respDown, respDownNot  in  128 each  driver-stage responses, valid while exDone is high.
REQ-014 respData / respValid / respReady  out / out / in  32 / 1 / 1  response word stream.
REQ-015 runDone  out  1  one-cycle pulse at the end of the batch.
REQ-016 errTimeout  out  1  sticky timeout flag, cleared by the next accepted runStart or by rst.
REQ-017 chalCount  out  16  challenges fully drained in the current batch.

Function
REQ-018 States: IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE.
REQ-019 IDLE + runStart: latch numChal, clear chalCount and errTimeout; go to DONE if numChal==0, otherwise go to FETCH.
REQ-020 FETCH: chalReady=1; on chalValid&&chalReady, latch chalData into challengeA/B, then go to ISSUE next cycle.
REQ-021 ISSUE: exStart=1; leave for WAIT only when at least MIN_START_CYCLES have elapsed and exDone is low; exStart is 0 in WAIT.
REQ-022 WAIT: on the first cycle exDone is high, capture all four responses into a 512-bit buffer, then go to DRAIN.
REQ-023 Timeout counter: cleared on entering ISSUE; counts in ISSUE and WAIT; on reaching TIMEOUT_CYCLES, set errTimeout, deassert exStart, go to DONE, emit no words for that challenge.
REQ-024 DRAIN emits 16 words, each 32 bits wide: respUp[31:0], [63:32], [95:64], [127:96], then respUpNot, respDown, respDownNot in the same low-to-high order.
REQ-025 respValid stays high while a word is pending; respData is stable until respValid&&respReady; no word is dropped or duplicated under any respReady pattern.
REQ-026 After word 15 is accepted: chalCount increments; if chalCount equals numChal, go to DONE, otherwise go to FETCH.
REQ-027 DONE: runDone=1 for exactly one cycle, then return to IDLE.
REQ-028 runStart outside IDLE has no effect; numChal changes mid-batch have no effect.
REQ-029 chalCount is 16 bits, so numChal=65535 completes without wrap.

Reset
REQ-030 rst in any state, including mid-ISSUE or mid-DRAIN, forces IDLE next cycle.
REQ-031 Reset values: exStart=0, chalReady=0, respValid=0, runDone=0, errTimeout=0, chalCount=0, challengeA/B=0, respData=0, response buffer=0.

Structure
REQ-032 A shared package puf_ctrl_pkg holds the state enum, RESP_WORDS=16 and CHAL_W=128.
REQ-033 One sub-module, resp_serializer, holds the 512-bit buffer, the 4-bit word index and the stream handshake.

Verification
REQ-034 numChal=1, challengeA=128'h0123..EF, driver model asserts exDone 1100 cycles after exStart -> exStart high >=8 cycles, then 16 words in the order of REQ-024, chalCount=1, one runDone pulse.
REQ-035 numChal=3 with respReady toggling 1/0 every cycle -> 48 words, none lost or duplicated, chalCount=3.
REQ-036 exDone left high from the previous run at exStart -> FSM stays in ISSUE until exDone falls and responses are not re-captured stale.
REQ-037 Driver model never raises exDone, TIMEOUT_CYCLES=64 -> errTimeout=1 at cycle 64, exStart=0, runDone pulse, 0 words.
REQ-038 numChal=0 -> runDone pulses 2 cycles after runStart, chalReady never asserts.
REQ-039 rst asserted during word 7 of DRAIN -> next cycle respValid=0 and IDLE; a new run then completes normally.
